// File: rtl/block_code_encoder.sv
// Systematic RS(n, n-2) encoder over GF(16): passes k data symbols, then appends two parity symbols.
// Optional BLOCK_ENC_CW_COUNT_EN adds a 16-bit count of completed codewords (cw_count).
module block_code_encoder #(
    parameter int DATA_WIDTH      = 4,
    parameter int MIN_CODE_LENGTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_data_valid,
    output logic                  tx_data_ready,
    input  logic [3:0]            code_length,
    output logic [DATA_WIDTH-1:0] tx_symbols,
    output logic                  tx_symbols_valid,
    output logic                  tx_symbols_last,
    input  logic                  tx_symbols_ready,
    output logic                  cfg_err
`ifdef BLOCK_ENC_CW_COUNT_EN
    ,
    output logic [15:0]           cw_count
`endif
);

    if (DATA_WIDTH != 4) begin : g_bad_width
        $error("block_code_encoder: DATA_WIDTH must be 4 (GF(16))");
    end

    localparam logic [3:0] G1      = 4'h6;
    localparam logic [3:0] G0      = 4'h8;
    localparam logic [3:0] MIN_LEN = 4'(MIN_CODE_LENGTH);

    // Handshakes: a transfer happens on any rising edge where valid and ready are
    // both high; valid never depends on ready, and a presented symbol is held until taken.

    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

    state_t                  state;
    logic [3:0]              k_q;
    logic [3:0]              cnt;
    logic                    par_sel;
    logic [DATA_WIDTH-1:0]   r0;
    logic [DATA_WIDTH-1:0]   r1;

    // Multiply in GF(2^4) with primitive polynomial x^4+x+1.
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] acc;
        logic [3:0] sh;
        acc = 4'h0;
        sh  = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = sh[3] ? ({sh[2:0], 1'b0} ^ 4'h3) : {sh[2:0], 1'b0};
        end
        return acc;
    endfunction

    logic       out_free;
    logic       len_ok;
    logic       in_hs;
    logic       out_hs;
    logic [3:0] fb;
    logic [3:0] cnt_nxt;

    assign out_free = ~tx_symbols_valid | tx_symbols_ready;
    assign len_ok   = code_length >= MIN_LEN;
    // The live length check closes the window between leaving reset/PARITY and cfg_err registering.
    assign tx_data_ready = (state != PARITY) & ~cfg_err & ~((state == IDLE) & ~len_ok) & out_free;
    assign in_hs    = tx_data_valid & tx_data_ready;
    assign out_hs   = tx_symbols_valid & tx_symbols_ready;
    assign fb       = tx_data ^ r1;
    assign cnt_nxt  = 4'(cnt + 4'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            k_q              <= 4'd0;
            cnt              <= 4'd0;
            par_sel          <= 1'b0;
            r0               <= '0;
            r1               <= '0;
            tx_symbols       <= '0;
            tx_symbols_valid <= 1'b0;
            tx_symbols_last  <= 1'b0;
            cfg_err          <= 1'b0;
        end else begin
            if (out_hs) begin
                tx_symbols_valid <= 1'b0;
                tx_symbols_last  <= 1'b0;
            end

            if (in_hs) begin
                r1               <= r0 ^ gf_mul(fb, G1);
                r0               <= gf_mul(fb, G0);
                tx_symbols       <= tx_data;
                tx_symbols_valid <= 1'b1;
                tx_symbols_last  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cfg_err <= ~len_ok;
                    if (in_hs) begin
                        k_q   <= 4'(code_length - 4'd2);
                        cnt   <= 4'd1;
                        state <= (code_length == MIN_LEN) ? PARITY : DATA;
                    end
                end
                DATA: begin
                    if (in_hs) begin
                        cnt <= cnt_nxt;
                        if (cnt_nxt == k_q) state <= PARITY;
                    end
                end
                PARITY: begin
                    if (out_free) begin
                        tx_symbols_valid <= 1'b1;
                        if (!par_sel) begin
                            tx_symbols      <= r1;
                            tx_symbols_last <= 1'b0;
                            par_sel         <= 1'b1;
                        end else begin
                            // Once r0 sits in the output register the next codeword may start.
                            tx_symbols      <= r0;
                            tx_symbols_last <= 1'b1;
                            r0              <= '0;
                            r1              <= '0;
                            par_sel         <= 1'b0;
                            cnt             <= 4'd0;
                            state           <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BLOCK_ENC_CW_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) cw_count <= 16'd0;
        else if (out_hs && tx_symbols_last) cw_count <= 16'(cw_count + 16'd1);
    end
`endif

endmodule
